seq_8by4_divider: RTL and testbench
===================================

# seq_8by4_divider

Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor, giving a 4-bit quotient and a 4-bit remainder. It is the inverse of the 4x4 array multiplier: any 8-bit product of that multiplier divided by one of its non-zero 4-bit operands returns the other operand with remainder 0. It produces one quotient bit per clock and uses a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath.

## Interface
- Parameters: none. Widths are fixed at 8/4/4/4.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge only while busy=0.
- dividend  input  8  unsigned dividend; captured on the accepted start edge.
- divisor  input  4  unsigned divisor; captured on the accepted start edge.
- busy  output  1  high while a division is iterating.
- done  output  1  one-cycle pulse marking valid quotient/remainder/flags.
- quotient  output  4  result quotient; held until the next accepted start.
- remainder  output  4  result remainder; held until the next accepted start.
- div_by_zero  output  1  the divisor captured for the last result was 0.
- overflow  output  1  the true quotient was >15 with divisor≠0.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, internal iteration counter=0.
- IDLE/DONE + start=1: latch divisor D.
  - If D==0: div_by_zero=1, overflow=0, quotient=4'hF, remainder=4'h0; go to DONE.
  - Else if dividend[7:4] >= D: overflow=1, div_by_zero=0, quotient=4'hF, remainder=4'h0; go to DONE.
  - Else: clear both flags, R=dividend[7:4], Q=dividend[3:0], count=0; go to CALC with busy=1.
- IDLE/DONE + start=0: DONE returns to IDLE; IDLE stays in IDLE.
- CALC, each edge:
  - T = {R, Q[3]} (5 bits). Compare zero-extended {1'b0,D} at 5 bits.
  - If T >= D: R = T − D (fits in 4 bits), shift in quotient bit 1; else R = T[3:0], shift in 0. Q = {Q[2:0], qbit}.
  - count increments. On the 4th iteration (count==3): load quotient=new Q and remainder=new R, then go to DONE.
- DONE: done=1 and busy=0 for exactly this one cycle.
- start while busy=1 is ignored, and the operands are not re-sampled.
- Invariant on every non-error result: quotient×divisor + remainder == dividend, and remainder < divisor.

## Timing
- Normal latency: start accepted on edge k. busy goes high after edge k and stays high through edge k+4. After edge k+4, done=1 and the results are valid. done stays high for one cycle.
- Error latency (div-by-zero or overflow): done=1 after edge k+1. busy never asserts.
- Back-to-back: start may be high during the DONE cycle. It is accepted on that edge, so done and the new busy are never high together. Throughput is one result per 5 cycles.
- quotient/remainder/flags update only on the edge that enters DONE; they are stable at all other times.
- rst=1 on any edge, including mid-CALC or during DONE, forces the reset state on that edge. It overrides start, and any in-flight operation is abandoned without a done pulse.

## Test plan
- Reset, then dividend=143, divisor=11, start for 1 cycle -> busy high for 4 cycles; done after the 4th CALC edge with quotient=13, remainder=0, flags=0.
- Sweep: 100/7 -> q=14, r=2; 200/13 -> q=15, r=5; 0/1 -> q=0, r=0. Exhaustively check all non-error 8×4 pairs against quotient×divisor+remainder==dividend and remainder<divisor.
- Errors: divisor=0 (any dividend) -> done one cycle after start, div_by_zero=1, q=F, r=0, busy never high. 160/10 -> overflow=1, q=F, r=0.
- Handshake: start toggled with new operands during CALC -> ignored, original result returned. start held high during DONE -> second operation begins, no done/busy overlap.
- Reset mid-operation: rst pulsed on the 2nd CALC edge -> all outputs 0, no done pulse. A subsequent 255/15 -> overflow=1 (15≥15).

Source files
------------

// File: rtl/seq_8by4_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock, start/busy/done handshake.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request, sampled only while busy=0
//   dividend[7:0]     unsigned dividend, captured on the accepted start edge
//   divisor[3:0]      unsigned divisor, captured on the accepted start edge
//   busy              high while iterating
//   done              one-cycle pulse, results and flags valid
//   quotient[3:0]     result quotient, held until the next result
//   remainder[3:0]    result remainder, held until the next result
//   div_by_zero       last captured divisor was 0
//   overflow          true quotient exceeded 15 with a non-zero divisor
module seq_8by4_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0] r_q;
    logic [3:0] q_q;
    logic [3:0] d_q;
    logic [1:0] cnt;

    logic       accept;
    logic       err_z;
    logic       err_o;
    logic [4:0] t;
    logic [4:0] diff;
    logic       ge;
    logic [3:0] r_nx;
    logic [3:0] q_nx;

    assign accept = start && (state != CALC);
    assign err_z  = (divisor == 4'd0);
    // The high nibble already being >= D means the quotient cannot fit in 4 bits.
    assign err_o  = (dividend[7:4] >= divisor);

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        t    = {r_q, q_q[3]};
        diff = t - {1'b0, d_q};
        ge   = (t >= {1'b0, d_q});
        r_nx = ge ? diff[3:0] : t[3:0];
        q_nx = {q_q[2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            CALC: begin
                busy = 1'b1;
                if (cnt == 2'd3) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nx = (err_z || err_o) ? DONE : CALC;
                else        state_nx = IDLE;
            end
            default: begin
                if (accept) state_nx = (err_z || err_o) ? DONE : CALC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= 4'd0;
            q_q         <= 4'd0;
            d_q         <= 4'd0;
            cnt         <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (state == CALC) begin
            r_q <= r_nx;
            q_q <= q_nx;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                quotient  <= q_nx;
                remainder <= r_nx;
            end
        end else if (accept) begin
            d_q <= divisor;
            if (err_z) begin
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
                quotient    <= 4'hF;
                remainder   <= 4'h0;
            end else if (err_o) begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b1;
                quotient    <= 4'hF;
                remainder   <= 4'h0;
            end else begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                r_q         <= dividend[7:4];
                q_q         <= dividend[3:0];
                cnt         <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_seq_8by4_divider.sv
// Self-checking bench for seq_8by4_divider: arithmetic reference model,
// per-cycle compare, directed literals, exhaustive sweep and random runs.
module tb_seq_8by4_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seq_8by4_divider dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Returns {dz, ov, q[3:0], r[3:0]} from plain integer division.
    function automatic [9:0] ref_div(input int a, input int b);
        if (b == 0) return {1'b1, 1'b0, 4'hF, 4'h0};
        if (a / b > 15) return {1'b0, 1'b1, 4'hF, 4'h0};
        return {1'b0, 1'b0, 4'(a / b), 4'(a % b)};
    endfunction

    // Reference model: cycles left busy, plus expected outputs.
    int         m_left = 0;
    bit         m_done = 0;
    logic [3:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;
    bit         m_dz = 0, m_ov = 0;
    logic [9:0] res;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0; m_done <= 0;
            m_q <= 0; m_r <= 0; m_dz <= 0; m_ov <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_q <= p_q; m_r <= p_r;
            end
        end else begin
            m_done <= 0;
            if (start) begin
                res = ref_div(int'(dividend), int'(divisor));
                m_dz <= res[9];
                m_ov <= res[8];
                if (res[9] || res[8]) begin
                    m_done <= 1; m_q <= res[7:4]; m_r <= res[3:0];
                end else begin
                    m_left <= 4; p_q <= res[7:4]; p_r <= res[3:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_left > 0));
            check("done", int'(done), int'(m_done));
            check("quotient", int'(quotient), int'(m_q));
            check("remainder", int'(remainder), int'(m_r));
            check("div_by_zero", int'(div_by_zero), int'(m_dz));
            check("overflow", int'(overflow), int'(m_ov));
        end
    end

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run(input logic [7:0] a, input logic [3:0] b, input bit noise);
        int n = 0;
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        while (!m_done && n < 10) begin
            if (noise && m_left > 0) begin
                start    = 1'($urandom);
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_seen", int'(done), 1);
    endtask

    task automatic lit(input string nm, input int q, input int r, input int dz, input int ov);
        check({nm, "_q"}, int'(quotient), q);
        check({nm, "_r"}, int'(remainder), r);
        check({nm, "_dz"}, int'(div_by_zero), dz);
        check({nm, "_ov"}, int'(overflow), ov);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        lit("reset", 0, 0, 0, 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: busy after accept edge for 4 cycles, then done.
        start = 1'b1; dividend = 8'd143; divisor = 4'd11;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("lat_busy", int'(busy), 1);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        check("lat_done", int'(done), 1);
        lit("143_11", 13, 0, 0, 0);
        @(negedge clk);

        run(8'd100, 4'd7, 0);  lit("100_7", 14, 2, 0, 0);
        run(8'd200, 4'd13, 0); lit("200_13", 15, 5, 0, 0);
        run(8'd0, 4'd1, 0);    lit("0_1", 0, 0, 0, 0);
        run(8'd77, 4'd0, 0);   lit("77_0", 15, 0, 1, 0);
        check("dz_busy", int'(busy), 0);
        run(8'd160, 4'd10, 0); lit("160_10", 15, 0, 0, 1);
        run(8'd143, 4'd11, 1); lit("noise_143_11", 13, 0, 0, 0);

        // Back-to-back: start during DONE cycle.
        run(8'd100, 4'd7, 0);
        start = 1'b1; dividend = 8'd200; divisor = 4'd13;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done", int'(done), 0);
        check("b2b_busy", int'(busy), 1);
        repeat (4) @(negedge clk);
        lit("b2b_200_13", 15, 5, 0, 0);

        // Reset on the 2nd CALC edge.
        @(negedge clk);
        start = 1'b1; dividend = 8'd143; divisor = 4'd11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        lit("midrst", 0, 0, 0, 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_nodone", int'(done), 0);
        end
        run(8'd255, 4'd15, 0); lit("255_15", 15, 0, 0, 1);

        // Exhaustive non-error pairs: invariant on DUT outputs.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                if (a / b <= 15) begin
                    run(8'(a), 4'(b), ($urandom_range(3) == 0));
                    check("inv_eq", int'(quotient) * b + int'(remainder), a);
                    check("inv_lt", int'(int'(remainder) < b), 1);
                end
            end
        end

        // Random operands, errors included.
        for (int i = 0; i < 300; i++) begin
            run(8'($urandom), 4'($urandom), 1'($urandom));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
